sample_readout: RTL and testbench

SAMPLE_READOUT -- requirements
Module: sample_readout

---
 rtl/readout_pkg.sv | 19 +
 rtl/sample_readout.sv | 137 +++++++++++++
 tb/tb_sample_readout.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/readout_pkg.sv
// Shared types and default widths for the sample RAM readout engine.
// CSUM only exists in the state encoding when READOUT_CHECKSUM_EN is defined.
package readout_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
`ifdef READOUT_CHECKSUM_EN
        CSUM,
`endif
        FIN
    } state_t;

endpackage

// File: rtl/sample_readout.sv
// Streams COUNT samples from an external 1-cycle-latency RAM onto a valid/ready byte link.
// Define READOUT_CHECKSUM_EN to append a mod-2^DATA_W checksum byte after the samples.
module sample_readout
    import readout_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [ADDR_W:0]   COUNT,
    input  logic              ABORT,
    output logic              BUSY,
    output logic              DONE,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    input  logic [DATA_W-1:0] RAM_DOUT,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY
);

    localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_q;
    logic [DATA_W-1:0] tx_data_q;
`ifdef READOUT_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
`endif
    logic              send_hs;
    logic              last;

    // ABORT wins over a handshake in the same cycle, so no counter moves on it.
    assign send_hs = (state_q == SEND) && TX_READY && !ABORT;
    assign last    = (rem_q == REM_ONE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = (COUNT == '0) ? FIN : READ;
                end
            end
            READ:  state_d = LATCH;
            LATCH: state_d = SEND;
            SEND: begin
                if (TX_READY) begin
`ifdef READOUT_CHECKSUM_EN
                    state_d = last ? CSUM : READ;
`else
                    state_d = last ? FIN : READ;
`endif
                end
            end
`ifdef READOUT_CHECKSUM_EN
            CSUM: begin
                if (TX_READY) begin
                    state_d = FIN;
                end
            end
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (ABORT && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        BUSY     = (state_q != IDLE);
        DONE     = (state_q == FIN);
        RAM_EN   = (state_q == READ);
`ifdef READOUT_CHECKSUM_EN
        TX_VALID = (state_q == SEND) || (state_q == CSUM);
`else
        TX_VALID = (state_q == SEND);
`endif
    end

    // The address only moves when another READ follows, so RAM_ADDR holds the last read address.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            addr_q    <= '0;
            rem_q     <= '0;
            tx_data_q <= '0;
`ifdef READOUT_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            if ((state_q == IDLE) && START) begin
                if (COUNT != '0) begin
                    addr_q <= START_ADDR;
                    rem_q  <= COUNT;
                end
`ifdef READOUT_CHECKSUM_EN
                sum_q <= '0;
`endif
            end
            if (state_q == LATCH) begin
                tx_data_q <= RAM_DOUT;
            end
            if (send_hs) begin
                rem_q <= rem_q - REM_ONE;
                if (!last) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
`ifdef READOUT_CHECKSUM_EN
                sum_q <= sum_q + tx_data_q;
                if (last) begin
                    tx_data_q <= sum_q + tx_data_q;
                end
`endif
            end
        end
    end

    assign RAM_WE   = 1'b0;
    assign RAM_ADDR = addr_q;
    assign TX_DATA  = tx_data_q;

endmodule

// File: tb/tb_sample_readout.sv
// Directed bench for sample_readout; RAM model returns addr[7:0] one cycle after RAM_EN.
// Expectations adapt to READOUT_CHECKSUM_EN (one extra byte, DONE one cycle later).
module tb_sample_readout;

`ifdef READOUT_CHECKSUM_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif

    logic        CLK;
    logic        RESET_N;
    logic        START;
    logic [12:0] START_ADDR;
    logic [13:0] COUNT;
    logic        ABORT;
    logic        BUSY;
    logic        DONE;
    logic        RAM_EN;
    logic        RAM_WE;
    logic [12:0] RAM_ADDR;
    logic [7:0]  RAM_DOUT;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;

    int checks = 0;
    int errors = 0;

    logic [7:0]  got_b[$];
    logic [12:0] got_a[$];
    int first_vld, done_cyc, done_n, end_cyc, abort_cyc;
    int stall_bad, stall_vld, vld_n, we_bad;
    bit tmo;

    sample_readout #(.ADDR_W(13), .DATA_W(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .START_ADDR(START_ADDR),
        .COUNT(COUNT), .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_DOUT(RAM_DOUT),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (RAM_EN) RAM_DOUT <= RAM_ADDR[7:0];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drives one START and records everything the DUT does until BUSY drops (bounded).
    task automatic collect(input logic [12:0] sa, input logic [13:0] cnt, input int stall_at,
                           input int stall_len, input int abort_hs, input int restart_at);
        int hs;
        logic [7:0] held;
        bit held_ok;
        got_b.delete(); got_a.delete();
        first_vld = -1; done_cyc = -1; done_n = 0; end_cyc = -1; abort_cyc = -1;
        stall_bad = 0; stall_vld = 0; vld_n = 0; we_bad = 0; tmo = 0;
        hs = 0; held = 8'h00; held_ok = 0;
        START_ADDR = sa; COUNT = cnt; START = 1'b1; ABORT = 1'b0; TX_READY = 1'b1;
        step();
        for (int cyc = 1; cyc <= 300; cyc++) begin
            START = 1'b0;
            if (!BUSY) begin
                end_cyc = cyc;
                break;
            end
            if (cyc == restart_at) begin
                START = 1'b1; START_ADDR = 13'h0AA; COUNT = 14'd2;
            end
            TX_READY = !(cyc >= stall_at && cyc < stall_at + stall_len);
            ABORT = (abort_hs > 0 && hs == abort_hs && abort_cyc < 0);
            if (ABORT) abort_cyc = cyc;
            if (RAM_WE) we_bad++;
            if (RAM_EN) got_a.push_back(RAM_ADDR);
            if (TX_VALID) begin
                vld_n++;
                if (first_vld < 0) first_vld = cyc;
            end
            if (!TX_READY) begin
                if (RAM_EN) stall_bad++;
                if (TX_VALID) stall_vld++;
                if (held_ok && TX_DATA !== held) stall_bad++;
                held = TX_DATA;
                held_ok = TX_VALID;
            end else begin
                held_ok = 0;
            end
            if (TX_VALID && TX_READY && !ABORT) begin
                got_b.push_back(TX_DATA);
                hs++;
            end
            if (DONE) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            step();
        end
        if (end_cyc < 0) tmo = 1;
        START = 1'b0; ABORT = 1'b0; TX_READY = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b1; START = 1'b0; ABORT = 1'b0; TX_READY = 1'b1;
        START_ADDR = '0; COUNT = '0;
        #3 RESET_N = 1'b0;
        #1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", DONE); end
        checks++; if (RAM_EN !== 1'b0) begin errors++; $display("FAIL reset_ram_en got %b expected 0", RAM_EN); end
        checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b expected 0", TX_VALID); end
        checks++; if (TX_DATA !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h expected 00", TX_DATA); end
        checks++; if (RAM_ADDR !== 13'h0) begin errors++; $display("FAIL reset_ram_addr got %h expected 0000", RAM_ADDR); end
        step(); step();
        RESET_N = 1'b1;
    endtask

    task automatic test_basic();
        collect(13'h010, 14'd4, 0, 0, 0, 4);
        checks++; if (tmo) begin errors++; $display("FAIL basic_timeout got timeout expected BUSY drop"); end
        checks++; if (got_b.size() != 4 + XTRA) begin errors++; $display("FAIL basic_nbytes got %0d expected %0d", got_b.size(), 4 + XTRA); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_b.size() <= i || got_b[i] !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL basic_byte%0d got %h expected %h", i, (got_b.size() > i) ? got_b[i] : 8'hxx, 8'h10 + 8'(i));
            end
        end
`ifdef READOUT_CHECKSUM_EN
        checks++; if (got_b.size() < 5 || got_b[4] !== 8'h46) begin errors++; $display("FAIL basic_checksum got %h expected 46", (got_b.size() > 4) ? got_b[4] : 8'hxx); end
`endif
        checks++; if (first_vld != 3) begin errors++; $display("FAIL basic_first_valid got cycle %0d expected 3", first_vld); end
        checks++; if (done_cyc != 13 + XTRA) begin errors++; $display("FAIL basic_done_cycle got %0d expected %0d", done_cyc, 13 + XTRA); end
        checks++; if (done_n != 1) begin errors++; $display("FAIL basic_done_count got %0d expected 1", done_n); end
        checks++; if (got_a.size() != 4 || got_a[0] !== 13'h010 || got_a[3] !== 13'h013) begin
            errors++; $display("FAIL basic_ram_reads got %0d reads expected 4 (010..013)", got_a.size());
        end
        checks++; if (we_bad != 0) begin errors++; $display("FAIL basic_ram_we got %0d writes expected 0", we_bad); end
    endtask

    task automatic test_wrap();
        logic [12:0] ea[4];
        logic [7:0]  eb[4];
        ea = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
        eb = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        collect(13'h1FFE, 14'd4, 0, 0, 0, 0);
        checks++; if (tmo || got_a.size() != 4) begin errors++; $display("FAIL wrap_reads got %0d expected 4", got_a.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_a.size() <= i || got_a[i] !== ea[i]) begin
                errors++; $display("FAIL wrap_addr%0d got %h expected %h", i, (got_a.size() > i) ? got_a[i] : 13'hx, ea[i]);
            end
            checks++;
            if (got_b.size() <= i || got_b[i] !== eb[i]) begin
                errors++; $display("FAIL wrap_byte%0d got %h expected %h", i, (got_b.size() > i) ? got_b[i] : 8'hxx, eb[i]);
            end
        end
    endtask

    task automatic test_stall();
        collect(13'h010, 14'd4, 6, 5, 0, 0);
        checks++; if (tmo) begin errors++; $display("FAIL stall_timeout got timeout expected BUSY drop"); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_stable got %0d violations expected 0", stall_bad); end
        checks++; if (stall_vld != 5) begin errors++; $display("FAIL stall_valid_cycles got %0d expected 5", stall_vld); end
        checks++; if (got_b.size() != 4 + XTRA) begin errors++; $display("FAIL stall_nbytes got %0d expected %0d", got_b.size(), 4 + XTRA); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_b.size() <= i || got_b[i] !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL stall_byte%0d got %h expected %h", i, (got_b.size() > i) ? got_b[i] : 8'hxx, 8'h10 + 8'(i));
            end
        end
        checks++; if (done_cyc != 18 + XTRA) begin errors++; $display("FAIL stall_done_cycle got %0d expected %0d", done_cyc, 18 + XTRA); end
        checks++; if (got_a.size() != 4) begin errors++; $display("FAIL stall_ram_reads got %0d expected 4", got_a.size()); end
    endtask

    task automatic test_abort();
        collect(13'h020, 14'd8, 0, 0, 2, 0);
        checks++; if (abort_cyc != 7 || end_cyc != 8) begin errors++; $display("FAIL abort_idle got end %0d abort %0d expected 8 7", end_cyc, abort_cyc); end
        checks++; if (done_n != 0) begin errors++; $display("FAIL abort_no_done got %0d expected 0", done_n); end
        checks++; if (got_b.size() != 2 || got_b[0] !== 8'h20 || got_b[1] !== 8'h21) begin
            errors++; $display("FAIL abort_bytes got %0d bytes expected 2 (20,21)", got_b.size());
        end
        checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL abort_tx_valid got %b expected 0", TX_VALID); end
        collect(13'h030, 14'd2, 0, 0, 0, 0);
        checks++; if (got_b.size() != 2 + XTRA || got_b[0] !== 8'h30 || got_b[1] !== 8'h31) begin
            errors++; $display("FAIL abort_restart_bytes got %0d bytes expected %0d (30,31)", got_b.size(), 2 + XTRA);
        end
        checks++; if (done_n != 1 || done_cyc != 7 + XTRA) begin errors++; $display("FAIL abort_restart_done got cycle %0d expected %0d", done_cyc, 7 + XTRA); end
    endtask

    task automatic test_count_zero();
        int idle_bad;
        collect(13'h055, 14'd0, 0, 0, 0, 1);
        checks++; if (done_n != 1 || done_cyc != 1) begin errors++; $display("FAIL zero_done got cycle %0d count %0d expected cycle 1 count 1", done_cyc, done_n); end
        checks++; if (got_a.size() != 0) begin errors++; $display("FAIL zero_ram_en got %0d reads expected 0", got_a.size()); end
        checks++; if (vld_n != 0) begin errors++; $display("FAIL zero_tx_valid got %0d cycles expected 0", vld_n); end
        checks++; if (end_cyc != 2) begin errors++; $display("FAIL zero_idle got cycle %0d expected 2", end_cyc); end
        idle_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (BUSY || RAM_EN || TX_VALID || DONE) idle_bad++;
            step();
        end
        checks++; if (idle_bad != 0) begin errors++; $display("FAIL zero_start_ignored got %0d active cycles expected 0", idle_bad); end
        checks++; if (RAM_ADDR !== 13'h031) begin errors++; $display("FAIL zero_addr_hold got %h expected 0031", RAM_ADDR); end
    endtask

    task automatic test_reset_mid();
        int bad;
        START_ADDR = 13'h010; COUNT = 14'd4; START = 1'b1;
        step();
        START = 1'b0;
        step(); step();
        checks++; if (TX_VALID !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got %b expected 1", TX_VALID); end
        #2 RESET_N = 1'b0;
        #1;
        checks++; if ({BUSY, DONE, RAM_EN, TX_VALID} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_ctrl got %b%b%b%b expected 0000", BUSY, DONE, RAM_EN, TX_VALID);
        end
        checks++; if (TX_DATA !== 8'h00 || RAM_ADDR !== 13'h0) begin
            errors++; $display("FAIL rstmid_data got %h/%h expected 00/0000", TX_DATA, RAM_ADDR);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (TX_VALID || DONE || BUSY) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_held got %0d active cycles expected 0", bad); end
        RESET_N = 1'b1;
        collect(13'h040, 14'd3, 0, 0, 0, 0);
        checks++; if (first_vld != 3) begin errors++; $display("FAIL rstmid_first_start got cycle %0d expected 3", first_vld); end
        checks++; if (got_b.size() != 3 + XTRA || got_b[0] !== 8'h40 || got_b[2] !== 8'h42) begin
            errors++; $display("FAIL rstmid_bytes got %0d bytes expected %0d (40..42)", got_b.size(), 3 + XTRA);
        end
        checks++; if (done_cyc != 10 + XTRA) begin errors++; $display("FAIL rstmid_done got cycle %0d expected %0d", done_cyc, 10 + XTRA); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_abort();
        test_count_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
